// File: rtl/debug_response_serializer_pkg.sv
// Shared definitions for the debug command path: serializer FSM encoding,
// response sizing and the command codes the debug decoder understands.
package debug_response_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_SEND    = 2'd3
   } dbg_state_e;

   localparam int MAX_RESP_BYTES = 4;

   localparam logic [5:0] CMD_CLK_LOW  = 6'b111000;
   localparam logic [5:0] CMD_CLK_HIGH = 6'b111111;

   // dbg_size encodes (bytes - 1)
   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      return {1'b0, size} + 3'd1;
   endfunction

endpackage

// File: rtl/debug_response_serializer_if.sv
// Command/decoder/transmitter signal bundle of the debug response serializer.
interface debug_response_serializer_if;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic [7:0]  dbg_code;
   logic [31:0] dbg_result;
   logic [1:0]  dbg_size;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        overrun;

   modport master (
      output cmd_valid, cmd_code, dbg_result, dbg_size, tx_ready,
      input  dbg_code, tx_data, tx_valid, busy, overrun
   );

   modport slave (
      input  cmd_valid, cmd_code, dbg_result, dbg_size, tx_ready,
      output dbg_code, tx_data, tx_valid, busy, overrun
   );
endinterface

// File: rtl/debug_response_serializer_shifter.sv
// Holds the not-yet-sent bytes of a captured decoder result and presents them
// one per advance, ordered by MSB_FIRST.
module debug_byte_shifter #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] load_data,
   input  logic [1:0]  load_size,
   output logic [7:0]  first_byte,
   output logic [7:0]  next_byte
);
   logic [31:0] shreg_q, shreg_d;
   logic [31:0] aligned;
   logic [4:0]  shamt;

   always_comb begin
      // MSB-first: move the highest selected byte to the top lane (8*(3-size))
      shamt      = {~load_size, 3'b000};
      aligned    = MSB_FIRST ? (load_data << shamt) : load_data;
      first_byte = MSB_FIRST ? aligned[31:24] : aligned[7:0];
      next_byte  = MSB_FIRST ? shreg_q[31:24] : shreg_q[7:0];
      shreg_d    = shreg_q;
      if (load)
         shreg_d = MSB_FIRST ? (aligned << 8) : (aligned >> 8);
      else if (advance)
         shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) shreg_q <= '0;
      else       shreg_q <= shreg_d;
   end
endmodule

// File: rtl/debug_response_serializer.sv
// Registers host command bytes onto the debug decoder, waits for its result to
// settle, then streams 1..4 result bytes to the UART transmitter.
//   state      | meaning
//   ST_IDLE    | waiting for cmd_valid; dbg_code holds last command
//   ST_SETTLE  | dbg_code driven, counting down decoder settle time
//   ST_CAPTURE | sample dbg_result/dbg_size, present first byte
//   ST_SEND    | valid/ready byte stream until the last byte is taken
module debug_response_serializer
   import debug_response_serializer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter bit MSB_FIRST     = 1'b1
) (
   input  logic                               clk,
   input  logic                               reset,
   debug_response_serializer_if.slave         bus
);
   dbg_state_e  state_q, state_d;
   logic [3:0]  settle_cnt_q, settle_cnt_d;
   logic [1:0]  bytes_left_q, bytes_left_d;
   logic [7:0]  dbg_code_q, dbg_code_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
   logic        shift_load, shift_adv;
   logic [7:0]  first_byte, next_byte;

   debug_byte_shifter #(.MSB_FIRST(MSB_FIRST)) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (shift_load),
      .advance    (shift_adv),
      .load_data  (bus.dbg_result),
      .load_size  (bus.dbg_size),
      .first_byte (first_byte),
      .next_byte  (next_byte)
   );

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      bytes_left_d = bytes_left_q;
      dbg_code_d   = dbg_code_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      busy_d       = busy_q;
      overrun_d    = overrun_q;
      shift_load   = 1'b0;
      shift_adv    = 1'b0;

      if (bus.cmd_valid && state_q != ST_IDLE) overrun_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               dbg_code_d   = bus.cmd_code;
               busy_d       = 1'b1;
               settle_cnt_d = 4'(SETTLE_CYCLES - 1);
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == 4'd0) state_d = ST_CAPTURE;
            else                      settle_cnt_d = settle_cnt_q - 4'd1;
         end
         ST_CAPTURE: begin
            shift_load   = 1'b1;
            bytes_left_d = bus.dbg_size;
            tx_data_d    = first_byte;
            tx_valid_d   = 1'b1;
            state_d      = ST_SEND;
         end
         ST_SEND: begin
            if (tx_valid_q && bus.tx_ready) begin
               if (bytes_left_q == 2'd0) begin
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  state_d    = ST_IDLE;
               end else begin
                  tx_data_d    = next_byte;
                  shift_adv    = 1'b1;
                  bytes_left_d = bytes_left_q - 2'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         bytes_left_q <= '0;
         dbg_code_q   <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         bytes_left_q <= bytes_left_d;
         dbg_code_q   <= dbg_code_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.dbg_code = dbg_code_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.busy     = busy_q;
   assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_debug_response_serializer.sv
// Directed bench for debug_response_serializer: one MSB-first and one
// LSB-first instance, received bytes gathered by a handshake monitor.
module tb_debug_response_serializer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   passed = 0;
   logic [7:0] rx_m[$];
   logic [7:0] rx_l[$];

   debug_response_serializer_if bus_m ();
   debug_response_serializer_if bus_l ();

   debug_response_serializer #(.SETTLE_CYCLES(2), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .bus(bus_m.slave));
   debug_response_serializer #(.SETTLE_CYCLES(2), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .bus(bus_l.slave));

   always #5 clk = ~clk;

   // inputs only change 1ns after posedge, so negedge values hold at the next edge
   always @(negedge clk) begin
      if (bus_m.tx_valid && bus_m.tx_ready) rx_m.push_back(bus_m.tx_data);
      if (bus_l.tx_valid && bus_l.tx_ready) rx_l.push_back(bus_l.tx_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input bit lsb, input logic [7:0] code);
      if (lsb) begin bus_l.cmd_valid = 1'b1; bus_l.cmd_code = code; end
      else     begin bus_m.cmd_valid = 1'b1; bus_m.cmd_code = code; end
      step();
      bus_l.cmd_valid = 1'b0;
      bus_m.cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(input bit lsb, output int cyc);
      cyc = 0;
      while (!(lsb ? bus_l.tx_valid : bus_m.tx_valid) && cyc < 60) begin
         step();
         cyc++;
      end
   endtask

   task automatic wait_idle(input bit lsb, output int cyc);
      cyc = 0;
      while ((lsb ? bus_l.busy : bus_m.busy) && cyc < 60) begin
         step();
         cyc++;
      end
   endtask

   function automatic logic [31:0] pack_rx(input bit lsb);
      logic [31:0] w = '0;
      if (lsb) foreach (rx_l[i]) w = {w[23:0], rx_l[i]};
      else     foreach (rx_m[i]) w = {w[23:0], rx_m[i]};
      return w;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      total += 6;
      if (bus_m.dbg_code !== 8'h00) $display("FAIL rst_dbg_code got %h exp 00", bus_m.dbg_code); else passed++;
      if (bus_m.tx_data !== 8'h00) $display("FAIL rst_tx_data got %h exp 00", bus_m.tx_data); else passed++;
      if (bus_m.tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %b exp 0", bus_m.tx_valid); else passed++;
      if (bus_m.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus_m.busy); else passed++;
      if (bus_m.overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", bus_m.overrun); else passed++;
      if (bus_l.tx_valid !== 1'b0) $display("FAIL rst_l_tx_valid got %b exp 0", bus_l.tx_valid); else passed++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_four_bytes();
      int lat, idle;
      rx_m.delete();
      bus_m.dbg_result = 32'hDEADBEEF; bus_m.dbg_size = 2'd3; bus_m.tx_ready = 1'b1;
      send_cmd(1'b0, 8'hC1);
      wait_valid(1'b0, lat);
      wait_idle(1'b0, idle);
      total += 5;
      if (bus_m.dbg_code !== 8'hC1) $display("FAIL four_dbg_code got %h exp c1", bus_m.dbg_code); else passed++;
      if (lat !== 3) $display("FAIL four_latency got %0d exp 3", lat); else passed++;
      if (idle !== 4) $display("FAIL four_send_cycles got %0d exp 4", idle); else passed++;
      if (rx_m.size() !== 4) $display("FAIL four_count got %0d exp 4", rx_m.size()); else passed++;
      if (pack_rx(1'b0) !== 32'hDEADBEEF) $display("FAIL four_bytes got %h exp deadbeef", pack_rx(1'b0)); else passed++;
   endtask

   task automatic test_single_byte();
      int lat, idle;
      rx_m.delete();
      bus_m.dbg_result = 32'h000000FF; bus_m.dbg_size = 2'd0; bus_m.tx_ready = 1'b1;
      send_cmd(1'b0, 8'h3F);
      wait_valid(1'b0, lat);
      wait_idle(1'b0, idle);
      step(); step();
      total += 5;
      if (rx_m.size() !== 1) $display("FAIL single_count got %0d exp 1", rx_m.size()); else passed++;
      if (pack_rx(1'b0) !== 32'h000000FF) $display("FAIL single_byte got %h exp ff", pack_rx(1'b0)); else passed++;
      if (bus_m.dbg_code !== 8'h3F) $display("FAIL single_dbg_code_hold got %h exp 3f", bus_m.dbg_code); else passed++;
      if (bus_m.busy !== 1'b0 || bus_m.tx_valid !== 1'b0) $display("FAIL single_idle busy %b valid %b exp 0 0", bus_m.busy, bus_m.tx_valid); else passed++;
      if (bus_m.overrun !== 1'b0) $display("FAIL single_overrun got %b exp 0", bus_m.overrun); else passed++;
   endtask

   task automatic test_stall();
      int lat, bad;
      rx_m.delete();
      bus_m.dbg_result = 32'h12345678; bus_m.dbg_size = 2'd1; bus_m.tx_ready = 1'b0;
      send_cmd(1'b0, 8'h41);
      wait_valid(1'b0, lat);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus_m.tx_data !== 8'h56 || bus_m.tx_valid !== 1'b1) bad++;
         step();
      end
      total += 1;
      if (bad !== 0 || bus_m.tx_data !== 8'h56) $display("FAIL stall_hold_first got %h (%0d bad cycles) exp 56", bus_m.tx_data, bad); else passed++;
      bus_m.tx_ready = 1'b1;
      step();
      bus_m.tx_ready = 1'b0;
      total += 1;
      if (bus_m.tx_data !== 8'h78 || bus_m.tx_valid !== 1'b1) $display("FAIL stall_next got %h valid %b exp 78 1", bus_m.tx_data, bus_m.tx_valid); else passed++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus_m.tx_data !== 8'h78 || bus_m.tx_valid !== 1'b1 || bus_m.busy !== 1'b1) bad++;
      end
      total += 1;
      if (bad !== 0) $display("FAIL stall_hold_second got %0d bad cycles exp 0", bad); else passed++;
      bus_m.tx_ready = 1'b1;
      step();
      total += 3;
      if (bus_m.busy !== 1'b0 || bus_m.tx_valid !== 1'b0) $display("FAIL stall_done busy %b valid %b exp 0 0", bus_m.busy, bus_m.tx_valid); else passed++;
      if (rx_m.size() !== 2) $display("FAIL stall_count got %0d exp 2", rx_m.size()); else passed++;
      if (pack_rx(1'b0) !== 32'h00005678) $display("FAIL stall_bytes got %h exp 00005678", pack_rx(1'b0)); else passed++;
   endtask

   task automatic test_lsb_first();
      int lat, idle;
      rx_l.delete();
      bus_l.dbg_result = 32'hAABBCCDD; bus_l.dbg_size = 2'd2; bus_l.tx_ready = 1'b1;
      send_cmd(1'b1, 8'h82);
      wait_valid(1'b1, lat);
      wait_idle(1'b1, idle);
      total += 3;
      if (lat !== 3) $display("FAIL lsb_latency got %0d exp 3", lat); else passed++;
      if (rx_l.size() !== 3) $display("FAIL lsb_count got %0d exp 3", rx_l.size()); else passed++;
      if (pack_rx(1'b1) !== 32'h00DDCCBB) $display("FAIL lsb_bytes got %h exp 00ddccbb", pack_rx(1'b1)); else passed++;
   endtask

   task automatic test_overrun();
      int lat, idle;
      rx_m.delete();
      bus_m.dbg_result = 32'hCAFEF00D; bus_m.dbg_size = 2'd3; bus_m.tx_ready = 1'b1;
      send_cmd(1'b0, 8'h81);
      send_cmd(1'b0, 8'h55);
      total += 2;
      if (bus_m.overrun !== 1'b1) $display("FAIL ovr_settle_flag got %b exp 1", bus_m.overrun); else passed++;
      if (bus_m.dbg_code !== 8'h81) $display("FAIL ovr_settle_code got %h exp 81", bus_m.dbg_code); else passed++;
      wait_valid(1'b0, lat);
      bus_m.dbg_result = 32'h00000000; bus_m.dbg_size = 2'd0;
      send_cmd(1'b0, 8'h66);
      wait_idle(1'b0, idle);
      total += 4;
      if (bus_m.dbg_code !== 8'h81) $display("FAIL ovr_send_code got %h exp 81", bus_m.dbg_code); else passed++;
      if (rx_m.size() !== 4) $display("FAIL ovr_count got %0d exp 4", rx_m.size()); else passed++;
      if (pack_rx(1'b0) !== 32'hCAFEF00D) $display("FAIL ovr_bytes got %h exp cafef00d", pack_rx(1'b0)); else passed++;
      if (bus_m.overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", bus_m.overrun); else passed++;
   endtask

   task automatic test_reset_mid_send();
      int lat, idle;
      rx_m.delete();
      bus_m.dbg_result = 32'hDEADBEEF; bus_m.dbg_size = 2'd3; bus_m.tx_ready = 1'b0;
      send_cmd(1'b0, 8'hC1);
      wait_valid(1'b0, lat);
      bus_m.tx_ready = 1'b1;
      step();
      bus_m.tx_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      total += 6;
      if (bus_m.tx_valid !== 1'b0) $display("FAIL rmid_tx_valid got %b exp 0", bus_m.tx_valid); else passed++;
      if (bus_m.busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", bus_m.busy); else passed++;
      if (bus_m.dbg_code !== 8'h00) $display("FAIL rmid_dbg_code got %h exp 00", bus_m.dbg_code); else passed++;
      if (bus_m.tx_data !== 8'h00) $display("FAIL rmid_tx_data got %h exp 00", bus_m.tx_data); else passed++;
      if (bus_m.overrun !== 1'b0) $display("FAIL rmid_overrun got %b exp 0", bus_m.overrun); else passed++;
      if (rx_m.size() !== 1 || pack_rx(1'b0) !== 32'h000000DE) $display("FAIL rmid_partial got %0d bytes %h exp 1 de", rx_m.size(), pack_rx(1'b0)); else passed++;
      step();
      reset = 1'b0;
      step();
      rx_m.delete();
      bus_m.dbg_result = 32'h0000A55A; bus_m.dbg_size = 2'd1; bus_m.tx_ready = 1'b1;
      send_cmd(1'b0, 8'h42);
      wait_valid(1'b0, lat);
      wait_idle(1'b0, idle);
      total += 4;
      if (lat !== 3) $display("FAIL rmid_next_latency got %0d exp 3", lat); else passed++;
      if (idle !== 2) $display("FAIL rmid_next_cycles got %0d exp 2", idle); else passed++;
      if (pack_rx(1'b0) !== 32'h0000A55A || rx_m.size() !== 2) $display("FAIL rmid_next_bytes got %h (%0d) exp a55a (2)", pack_rx(1'b0), rx_m.size()); else passed++;
      if (bus_m.dbg_code !== 8'h42) $display("FAIL rmid_next_code got %h exp 42", bus_m.dbg_code); else passed++;
   endtask

   initial begin
      bus_m.cmd_valid = 1'b0; bus_m.cmd_code = '0; bus_m.dbg_result = '0; bus_m.dbg_size = '0; bus_m.tx_ready = 1'b0;
      bus_l.cmd_valid = 1'b0; bus_l.cmd_code = '0; bus_l.dbg_result = '0; bus_l.dbg_size = '0; bus_l.tx_ready = 1'b0;
      #1;
      test_reset();
      test_four_bytes();
      test_single_byte();
      test_stall();
      test_lsb_first();
      test_overrun();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
